// File: rtl/regfile_seq_ctrl_if.sv
// Instruction handshake and data-memory port of the register-file sequencer.
// The sequencer connects as master; the fetch unit and memory model connect as slave.
interface regfile_seq_ctrl_if;
    logic        instr_valid;
    logic        instr_ready;
    logic [15:0] instr;
    logic        mem_req;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        mem_ack;

    modport master (
        input  instr_valid, instr, mem_rdata, mem_ack,
        output instr_ready, mem_req, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        output instr_valid, instr, mem_rdata, mem_ack,
        input  instr_ready, mem_req, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/regfile_seq_ctrl.sv
// Multi-cycle sequencer for the 4x16 register file: decode, ALU, load/store, write-back.
// Optional macro CTRL_MEM_TIMEOUT_EN bounds the MEM wait to MEM_TIMEOUT cycles.
module regfile_seq_ctrl #(
    parameter int MEM_TIMEOUT = 64
) (
    input  logic               clk,
    input  logic               rst_n,
    regfile_seq_ctrl_if.master bus,
    output logic [1:0]         rs1_addr,
    output logic [1:0]         rs2_addr,
    input  logic [15:0]        rs1_data,
    input  logic [15:0]        rs2_data,
    output logic [1:0]         rd_addr,
    output logic [15:0]        rd_data,
    output logic               write_enable,
    output logic               busy,
    output logic               halted,
    output logic               err,
    output logic [15:0]        retired_count
);

    if (MEM_TIMEOUT < 1 || MEM_TIMEOUT > 65535) begin : g_bad_mem_timeout
        $error("MEM_TIMEOUT must be in 1..65535");
    end

    typedef enum logic [2:0] {S_IDLE, S_EXEC, S_MEM, S_WB, S_HALTED} state_t;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_ADD  = 4'h1;
    localparam logic [3:0] OP_SUB  = 4'h2;
    localparam logic [3:0] OP_AND  = 4'h3;
    localparam logic [3:0] OP_OR   = 4'h4;
    localparam logic [3:0] OP_XOR  = 4'h5;
    localparam logic [3:0] OP_ADDI = 4'h6;
    localparam logic [3:0] OP_LDI  = 4'h7;
    localparam logic [3:0] OP_LD   = 4'h8;
    localparam logic [3:0] OP_ST   = 4'h9;
    localparam logic [3:0] OP_HALT = 4'hF;

    function automatic logic [15:0] alu(input logic [3:0]  op,
                                        input logic [15:0] a,
                                        input logic [15:0] b,
                                        input logic [7:0]  imm);
        logic signed [15:0] a_s;
        logic signed [15:0] imm_s;
        logic [15:0]        res;
        a_s   = signed'(a);
        imm_s = signed'({{8{imm[7]}}, imm});
        case (op)
            OP_ADD:  res = a + b;
            OP_SUB:  res = a - b;
            OP_AND:  res = a & b;
            OP_OR:   res = a | b;
            OP_XOR:  res = a ^ b;
            OP_ADDI: res = a_s + imm_s;
            OP_LDI:  res = {8'h00, imm};
            default: res = 16'h0000;
        endcase
        return res;
    endfunction

    state_t      state_q, state_d;
    logic [15:0] ir_q, ir_d;
    logic [1:0]  rs1_addr_q, rs1_addr_d;
    logic [1:0]  rs2_addr_q, rs2_addr_d;
    logic [1:0]  rd_addr_q, rd_addr_d;
    logic [15:0] rd_data_q, rd_data_d;
    logic        we_q, we_d;
    logic        mem_req_q, mem_req_d;
    logic        mem_we_q, mem_we_d;
    logic [15:0] mem_addr_q, mem_addr_d;
    logic [15:0] mem_wdata_q, mem_wdata_d;
    logic        err_q, err_d;
    logic [15:0] retired_q, retired_d;
    logic        retire;
    logic [3:0]  op;
    logic [15:0] op_a;
    logic [15:0] op_b;

`ifdef CTRL_MEM_TIMEOUT_EN
    logic [15:0] tmo_q, tmo_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) tmo_q <= 16'h0000;
        else        tmo_q <= tmo_d;
    end
`endif

    always_comb begin
        state_d     = state_q;
        ir_d        = ir_q;
        rs1_addr_d  = rs1_addr_q;
        rs2_addr_d  = rs2_addr_q;
        rd_addr_d   = rd_addr_q;
        rd_data_d   = rd_data_q;
        we_d        = 1'b0;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        err_d       = err_q;
        retire      = 1'b0;
`ifdef CTRL_MEM_TIMEOUT_EN
        tmo_d       = tmo_q;
`endif
        op   = ir_q[15:12];
        // Register 0 reads as zero regardless of what the regfile returns.
        op_a = (ir_q[9:8] == 2'd0) ? 16'h0000 : rs1_data;
        op_b = (ir_q[7:6] == 2'd0) ? 16'h0000 : rs2_data;

        case (state_q)
            S_IDLE: begin
                if (bus.instr_valid) begin
                    ir_d       = bus.instr;
                    rs1_addr_d = bus.instr[9:8];
                    rs2_addr_d = bus.instr[7:6];
                    state_d    = S_EXEC;
                end
            end
            S_EXEC: begin
                case (op)
                    OP_NOP: begin
                        retire  = 1'b1;
                        state_d = S_IDLE;
                    end
                    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_ADDI, OP_LDI: begin
                        rd_addr_d = ir_q[11:10];
                        rd_data_d = alu(op, op_a, op_b, ir_q[7:0]);
                        we_d      = 1'b1;
                        state_d   = S_WB;
                    end
                    OP_LD, OP_ST: begin
                        mem_addr_d  = op_a;
                        mem_wdata_d = (op == OP_ST) ? op_b : mem_wdata_q;
                        mem_we_d    = (op == OP_ST);
                        mem_req_d   = 1'b1;
                        state_d     = S_MEM;
`ifdef CTRL_MEM_TIMEOUT_EN
                        tmo_d       = 16'h0000;
`endif
                    end
                    OP_HALT: begin
                        retire  = 1'b1;
                        state_d = S_HALTED;
                    end
                    default: begin
                        err_d   = 1'b1;
                        state_d = S_IDLE;
                    end
                endcase
            end
            S_MEM: begin
                // An ack arriving on the timeout cycle still completes normally.
                if (bus.mem_ack) begin
                    mem_req_d = 1'b0;
                    if (mem_we_q) begin
                        retire  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        rd_addr_d = ir_q[11:10];
                        rd_data_d = bus.mem_rdata;
                        we_d      = 1'b1;
                        state_d   = S_WB;
                    end
                end
`ifdef CTRL_MEM_TIMEOUT_EN
                else if (tmo_q == 16'(MEM_TIMEOUT - 1)) begin
                    mem_req_d = 1'b0;
                    err_d     = 1'b1;
                    state_d   = S_IDLE;
                end else begin
                    tmo_d = tmo_q + 16'd1;
                end
`endif
            end
            S_WB: begin
                retire  = 1'b1;
                state_d = S_IDLE;
            end
            S_HALTED: begin
                state_d = S_HALTED;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        retired_d = retire ? retired_q + 16'd1 : retired_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            ir_q        <= 16'h0000;
            rs1_addr_q  <= 2'd0;
            rs2_addr_q  <= 2'd0;
            rd_addr_q   <= 2'd0;
            rd_data_q   <= 16'h0000;
            we_q        <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= 16'h0000;
            mem_wdata_q <= 16'h0000;
            err_q       <= 1'b0;
            retired_q   <= 16'h0000;
        end else begin
            state_q     <= state_d;
            ir_q        <= ir_d;
            rs1_addr_q  <= rs1_addr_d;
            rs2_addr_q  <= rs2_addr_d;
            rd_addr_q   <= rd_addr_d;
            rd_data_q   <= rd_data_d;
            we_q        <= we_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            err_q       <= err_d;
            retired_q   <= retired_d;
        end
    end

    assign bus.instr_ready = (state_q == S_IDLE);
    assign bus.mem_req     = mem_req_q;
    assign bus.mem_we      = mem_we_q;
    assign bus.mem_addr    = mem_addr_q;
    assign bus.mem_wdata   = mem_wdata_q;
    assign rs1_addr        = rs1_addr_q;
    assign rs2_addr        = rs2_addr_q;
    assign rd_addr         = rd_addr_q;
    assign rd_data         = rd_data_q;
    assign write_enable    = we_q;
    assign busy            = (state_q != S_IDLE) && (state_q != S_HALTED);
    assign halted          = (state_q == S_HALTED);
    assign err             = err_q;
    assign retired_count   = retired_q;

endmodule

// File: tb/tb_regfile_seq_ctrl.sv
// Directed bench for regfile_seq_ctrl with a behavioural 4x16 regfile and a hand-driven memory port.
module tb_regfile_seq_ctrl;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  rs1_addr;
    logic [1:0]  rs2_addr;
    logic [15:0] rs1_data;
    logic [15:0] rs2_data;
    logic [1:0]  rd_addr;
    logic [15:0] rd_data;
    logic        write_enable;
    logic        busy;
    logic        halted;
    logic        err;
    logic [15:0] retired_count;
    logic [15:0] regs [4] = '{default: 16'h0000};
    int          checks = 0;
    int          errors = 0;
    int          exp_ret = 0;

    always #5 clk = ~clk;

    regfile_seq_ctrl_if bus ();

    regfile_seq_ctrl #(.MEM_TIMEOUT(4)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .bus           (bus),
        .rs1_addr      (rs1_addr),
        .rs2_addr      (rs2_addr),
        .rs1_data      (rs1_data),
        .rs2_data      (rs2_data),
        .rd_addr       (rd_addr),
        .rd_data       (rd_data),
        .write_enable  (write_enable),
        .busy          (busy),
        .halted        (halted),
        .err           (err),
        .retired_count (retired_count)
    );

    // r0 returns garbage so that the zero-forcing of operand 0 is visible.
    assign rs1_data = (rs1_addr == 2'd0) ? 16'hDEAD : regs[rs1_addr];
    assign rs2_data = (rs2_addr == 2'd0) ? 16'hDEAD : regs[rs2_addr];

    always @(posedge clk) begin
        if (write_enable && rd_addr != 2'd0) regs[rd_addr] <= rd_data;
    end

    // Called mid-cycle; returns just after the handshake edge.
    task automatic issue(input logic [15:0] i);
        checks++;
        if (bus.instr_ready !== 1'b1) begin errors++; $display("FAIL issue_ready: got %b expected 1", bus.instr_ready); end
        bus.instr_valid = 1'b1;
        bus.instr       = i;
        @(posedge clk); #1;
        bus.instr_valid = 1'b0;
    endtask

    task automatic run_wb(input logic [15:0] i, input logic [1:0] exp_rd, input logic [15:0] exp_data, input string name);
        issue(i);
        @(negedge clk);
        checks++;
        if (busy !== 1'b1 || write_enable !== 1'b0) begin errors++; $display("FAIL %s_exec: busy=%b we=%b expected busy=1 we=0", name, busy, write_enable); end
        @(negedge clk);
        checks++;
        if (write_enable !== 1'b1) begin errors++; $display("FAIL %s_we: got %b expected 1", name, write_enable); end
        checks++;
        if (rd_addr !== exp_rd) begin errors++; $display("FAIL %s_rd_addr: got %0d expected %0d", name, rd_addr, exp_rd); end
        checks++;
        if (rd_data !== exp_data) begin errors++; $display("FAIL %s_rd_data: got %h expected %h", name, rd_data, exp_data); end
        @(negedge clk);
        exp_ret++;
        checks++;
        if (bus.instr_ready !== 1'b1 || write_enable !== 1'b0) begin errors++; $display("FAIL %s_done: ready=%b we=%b expected ready=1 we=0", name, bus.instr_ready, write_enable); end
        checks++;
        if (retired_count !== 16'(exp_ret)) begin errors++; $display("FAIL %s_retired: got %0d expected %0d", name, retired_count, exp_ret); end
    endtask

    task automatic test_reset();
        bus.instr_valid = 1'b0;
        bus.instr       = 16'h0000;
        bus.mem_ack     = 1'b0;
        bus.mem_rdata   = 16'h0000;
        rst_n           = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (bus.instr_ready !== 1'b1 || busy !== 1'b0 || halted !== 1'b0 || err !== 1'b0) begin
            errors++; $display("FAIL reset_status: ready=%b busy=%b halted=%b err=%b expected 1 0 0 0", bus.instr_ready, busy, halted, err);
        end
        checks++;
        if (write_enable !== 1'b0 || bus.mem_req !== 1'b0 || bus.mem_we !== 1'b0) begin
            errors++; $display("FAIL reset_strobes: we=%b req=%b mem_we=%b expected 0 0 0", write_enable, bus.mem_req, bus.mem_we);
        end
        checks++;
        if (rd_data !== 16'h0 || rd_addr !== 2'd0 || bus.mem_addr !== 16'h0 || bus.mem_wdata !== 16'h0 || retired_count !== 16'h0) begin
            errors++; $display("FAIL reset_regs: rd_data=%h rd_addr=%0d addr=%h wdata=%h ret=%0d expected all 0", rd_data, rd_addr, bus.mem_addr, bus.mem_wdata, retired_count);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.instr_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready: got %b expected 1", bus.instr_ready); end
    endtask

    task automatic test_ldi();
        run_wb(16'h747F, 2'd1, 16'h007F, "ldi_r1");
        run_wb(16'h7881, 2'd2, 16'h0081, "ldi_r2");
        checks++;
        if (regs[1] !== 16'h007F || regs[2] !== 16'h0081) begin errors++; $display("FAIL ldi_regs: r1=%h r2=%h expected 007f 0081", regs[1], regs[2]); end
    endtask

    task automatic test_alu();
        run_wb(16'h1D80, 2'd3, 16'h0100, "add");
        run_wb(16'h2E40, 2'd3, 16'h0002, "sub");
        run_wb(16'h2D80, 2'd3, 16'hFFFE, "sub_wrap");
        run_wb(16'h6DFF, 2'd3, 16'h007E, "addi_neg");
        run_wb(16'h6E05, 2'd3, 16'h0086, "addi_pos");
        run_wb(16'h1C40, 2'd3, 16'h007F, "add_r0");
        run_wb(16'h3D80, 2'd3, 16'h0001, "and");
        run_wb(16'h4D80, 2'd3, 16'h00FF, "or");
        run_wb(16'h5D80, 2'd3, 16'h00FE, "xor");
    endtask

    task automatic test_store();
        issue(16'h9180);
        @(negedge clk);
        checks++;
        if (bus.mem_req !== 1'b0) begin errors++; $display("FAIL st_exec_req: got %b expected 0", bus.mem_req); end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++;
            if (bus.mem_req !== 1'b1 || bus.mem_we !== 1'b1 || bus.mem_addr !== 16'h007F || bus.mem_wdata !== 16'h0081 || write_enable !== 1'b0) begin
                errors++; $display("FAIL st_mem_cycle%0d: req=%b we=%b addr=%h wdata=%h rf_we=%b expected 1 1 007f 0081 0", c, bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata, write_enable);
            end
            if (c == 2) bus.mem_ack = 1'b1;
        end
        @(posedge clk); #1;
        bus.mem_ack = 1'b0;
        @(negedge clk);
        exp_ret++;
        checks++;
        if (bus.mem_req !== 1'b0 || bus.instr_ready !== 1'b1 || write_enable !== 1'b0) begin
            errors++; $display("FAIL st_done: req=%b ready=%b we=%b expected 0 1 0", bus.mem_req, bus.instr_ready, write_enable);
        end
        checks++;
        if (retired_count !== 16'(exp_ret)) begin errors++; $display("FAIL st_retired: got %0d expected %0d", retired_count, exp_ret); end
    endtask

    task automatic test_load();
        issue(16'h8D00);
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (bus.mem_req !== 1'b1 || bus.mem_we !== 1'b0 || bus.mem_addr !== 16'h007F) begin
            errors++; $display("FAIL ld_mem: req=%b we=%b addr=%h expected 1 0 007f", bus.mem_req, bus.mem_we, bus.mem_addr);
        end
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 16'hBEEF;
        @(posedge clk); #1;
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = 16'h0000;
        @(negedge clk);
        checks++;
        if (write_enable !== 1'b1 || rd_addr !== 2'd3 || rd_data !== 16'hBEEF || bus.mem_req !== 1'b0) begin
            errors++; $display("FAIL ld_wb: we=%b rd=%0d data=%h req=%b expected 1 3 beef 0", write_enable, rd_addr, rd_data, bus.mem_req);
        end
        @(negedge clk);
        exp_ret++;
        checks++;
        if (regs[3] !== 16'hBEEF || retired_count !== 16'(exp_ret)) begin
            errors++; $display("FAIL ld_done: r3=%h ret=%0d expected beef %0d", regs[3], retired_count, exp_ret);
        end
    endtask

    task automatic test_illegal_halt();
        issue(16'hA000);
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (err !== 1'b1 || write_enable !== 1'b0 || bus.mem_req !== 1'b0 || bus.instr_ready !== 1'b1) begin
            errors++; $display("FAIL illegal: err=%b we=%b req=%b ready=%b expected 1 0 0 1", err, write_enable, bus.mem_req, bus.instr_ready);
        end
        checks++;
        if (retired_count !== 16'(exp_ret)) begin errors++; $display("FAIL illegal_retired: got %0d expected %0d", retired_count, exp_ret); end
        issue(16'hF000);
        @(negedge clk);
        @(negedge clk);
        exp_ret++;
        checks++;
        if (halted !== 1'b1 || busy !== 1'b0 || bus.instr_ready !== 1'b0 || err !== 1'b1) begin
            errors++; $display("FAIL halt: halted=%b busy=%b ready=%b err=%b expected 1 0 0 1", halted, busy, bus.instr_ready, err);
        end
        checks++;
        if (retired_count !== 16'(exp_ret)) begin errors++; $display("FAIL halt_retired: got %0d expected %0d", retired_count, exp_ret); end
        bus.instr_valid = 1'b1;
        bus.instr       = 16'h747F;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            checks++;
            if (bus.instr_ready !== 1'b0 || halted !== 1'b1 || write_enable !== 1'b0) begin
                errors++; $display("FAIL halt_hold%0d: ready=%b halted=%b we=%b expected 0 1 0", c, bus.instr_ready, halted, write_enable);
            end
        end
        bus.instr_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        exp_ret = 0;
        checks++;
        if (err !== 1'b0 || halted !== 1'b0 || retired_count !== 16'h0) begin
            errors++; $display("FAIL halt_reset: err=%b halted=%b ret=%0d expected 0 0 0", err, halted, retired_count);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset_mid_mem();
        issue(16'h8D00);
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (bus.mem_req !== 1'b1) begin errors++; $display("FAIL rstmem_req_before: got %b expected 1", bus.mem_req); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.mem_req !== 1'b0 || write_enable !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL rstmem_abort: req=%b we=%b busy=%b expected 0 0 0", bus.mem_req, write_enable, busy);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.instr_ready !== 1'b1 || retired_count !== 16'h0 || regs[3] !== 16'hBEEF) begin
            errors++; $display("FAIL rstmem_after: ready=%b ret=%0d r3=%h expected 1 0 beef", bus.instr_ready, retired_count, regs[3]);
        end
    endtask

`ifdef CTRL_MEM_TIMEOUT_EN
    task automatic test_mem_timeout();
        issue(16'h8D00);
        @(negedge clk);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            checks++;
            if (bus.mem_req !== 1'b1 || err !== 1'b0) begin errors++; $display("FAIL tmo_wait%0d: req=%b err=%b expected 1 0", c, bus.mem_req, err); end
        end
        @(negedge clk);
        checks++;
        if (bus.mem_req !== 1'b0 || err !== 1'b1 || bus.instr_ready !== 1'b1 || write_enable !== 1'b0 || retired_count !== 16'(exp_ret)) begin
            errors++; $display("FAIL tmo_expire: req=%b err=%b ready=%b we=%b ret=%0d expected 0 1 1 0 %0d", bus.mem_req, err, bus.instr_ready, write_enable, retired_count, exp_ret);
        end
        issue(16'h8D00);
        @(negedge clk);
        repeat (3) @(negedge clk);
        @(negedge clk);
        checks++;
        if (bus.mem_req !== 1'b1) begin errors++; $display("FAIL tmo_edge_req: got %b expected 1", bus.mem_req); end
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 16'h1234;
        @(posedge clk); #1;
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = 16'h0000;
        @(negedge clk);
        checks++;
        if (write_enable !== 1'b1 || rd_data !== 16'h1234) begin errors++; $display("FAIL tmo_edge_wb: we=%b data=%h expected 1 1234", write_enable, rd_data); end
        @(negedge clk);
        exp_ret++;
        checks++;
        if (retired_count !== 16'(exp_ret) || bus.instr_ready !== 1'b1) begin
            errors++; $display("FAIL tmo_edge_done: ret=%0d ready=%b expected %0d 1", retired_count, bus.instr_ready, exp_ret);
        end
    endtask
`else
    task automatic test_mem_wait();
        issue(16'h8D00);
        @(negedge clk);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            checks++;
            if (bus.mem_req !== 1'b1 || err !== 1'b0) begin errors++; $display("FAIL wait%0d: req=%b err=%b expected 1 0", c, bus.mem_req, err); end
        end
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 16'h1234;
        @(posedge clk); #1;
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = 16'h0000;
        @(negedge clk);
        checks++;
        if (write_enable !== 1'b1 || rd_data !== 16'h1234) begin errors++; $display("FAIL wait_wb: we=%b data=%h expected 1 1234", write_enable, rd_data); end
        @(negedge clk);
        exp_ret++;
        checks++;
        if (retired_count !== 16'(exp_ret)) begin errors++; $display("FAIL wait_retired: got %0d expected %0d", retired_count, exp_ret); end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_ldi();
        test_alu();
        test_store();
        test_load();
        test_illegal_halt();
        test_reset_mid_mem();
`ifdef CTRL_MEM_TIMEOUT_EN
        test_mem_timeout();
`else
        test_mem_wait();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
